// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with instruction register,
// BYPASS/IDCODE data registers, TDO mux and boundary-scan cell controls.
// Optional feature macro JTAG_TAP_IDCODE_EN: when defined, the IDCODE
// instruction and register exist and IDCODE is the reset instruction;
// otherwise opcode 2 decodes as BYPASS and BYPASS is the reset instruction.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  input  logic                bsr_so,
  output logic                tdo,
  output logic                tdo_en,
  output logic                capture_en,
  output logic                shift_dr,
  output logic                update_en,
  output logic                mode,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] instr
);

  localparam logic [3:0] TLR   = 4'hF;
  localparam logic [3:0] RTI   = 4'hC;
  localparam logic [3:0] SELDR = 4'h7;
  localparam logic [3:0] CAPDR = 4'h6;
  localparam logic [3:0] SHDR  = 4'h2;
  localparam logic [3:0] EX1DR = 4'h1;
  localparam logic [3:0] PAUDR = 4'h3;
  localparam logic [3:0] EX2DR = 4'h0;
  localparam logic [3:0] UPDDR = 4'h5;
  localparam logic [3:0] SELIR = 4'h4;
  localparam logic [3:0] CAPIR = 4'hE;
  localparam logic [3:0] SHIR  = 4'hA;
  localparam logic [3:0] EX1IR = 4'h9;
  localparam logic [3:0] PAUIR = 4'hB;
  localparam logic [3:0] EX2IR = 4'h8;
  localparam logic [3:0] UPDIR = 4'hD;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic                IDCODE_EN = 1'b1;
  localparam logic [IR_WIDTH-1:0] RESET_OP  = OP_IDCODE;
`else
  localparam logic                IDCODE_EN = 1'b0;
  localparam logic [IR_WIDTH-1:0] RESET_OP  = OP_BYPASS;
`endif

  logic [3:0]          state_q;
  logic [3:0]          state_d;
  logic [IR_WIDTH-1:0] ir_shift;
  logic                bypass_q;
  logic [31:0]         idcode_q;
  logic                sel_bsr;
  logic                sel_idcode;
  logic                sel_bypass;
  logic                dr_out;

  // Data register selection; unknown opcodes fall through to BYPASS.
  // With IDCODE disabled sel_idcode is constant 0 and idcode_q folds away.
  assign sel_bsr    = (instr == OP_EXTEST) || (instr == OP_SAMPLE);
  assign sel_idcode = IDCODE_EN && (instr == OP_IDCODE);
  assign sel_bypass = !sel_bsr && !sel_idcode;

  // Standard 1149.1 TAP next-state decode from TMS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tms ? TLR   : RTI;
      RTI:     state_d = tms ? SELDR : RTI;
      SELDR:   state_d = tms ? SELIR : CAPDR;
      CAPDR:   state_d = tms ? EX1DR : SHDR;
      SHDR:    state_d = tms ? EX1DR : SHDR;
      EX1DR:   state_d = tms ? UPDDR : PAUDR;
      PAUDR:   state_d = tms ? EX2DR : PAUDR;
      EX2DR:   state_d = tms ? UPDDR : SHDR;
      UPDDR:   state_d = tms ? SELDR : RTI;
      SELIR:   state_d = tms ? TLR   : CAPIR;
      CAPIR:   state_d = tms ? EX1IR : SHIR;
      SHIR:    state_d = tms ? EX1IR : SHIR;
      EX1IR:   state_d = tms ? UPDIR : PAUIR;
      PAUIR:   state_d = tms ? EX2IR : PAUIR;
      EX2IR:   state_d = tms ? UPDIR : SHIR;
      UPDIR:   state_d = tms ? SELDR : RTI;
      default: state_d = TLR;
    endcase
  end

  // TAP state register.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state_q <= TLR;
    else         state_q <= state_d;
  end

  // IR shift stage: capture 01 pattern, shift TDI into the MSB.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)                ir_shift <= IR_CAPTURE;
    else if (state_q == CAPIR)  ir_shift <= IR_CAPTURE;
    else if (state_q == SHIR)   ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
  end

  // Active instruction: forced to the reset opcode in TLR, loaded on leaving UpdIR.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)                instr <= RESET_OP;
    else if (state_q == TLR)    instr <= RESET_OP;
    else if (state_q == UPDIR)  instr <= ir_shift;
  end

  // One-bit BYPASS register.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)                              bypass_q <= 1'b0;
    else if (sel_bypass && state_q == CAPDR)  bypass_q <= 1'b0;
    else if (sel_bypass && state_q == SHDR)   bypass_q <= tdi;
  end

  // 32-bit IDCODE register, shifted out LSB first.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n)                              idcode_q <= IDCODE_VAL;
    else if (sel_idcode && state_q == CAPDR)  idcode_q <= IDCODE_VAL;
    else if (sel_idcode && state_q == SHDR)   idcode_q <= {tdi, idcode_q[31:1]};
  end

  assign dr_out = sel_bsr    ? bsr_so      :
                  sel_idcode ? idcode_q[0] : bypass_q;

  // TDO launches on the falling edge; holds its last value outside shift states.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if (state_q == SHIR) begin
      tdo    <= ir_shift[0];
      tdo_en <= 1'b1;
    end else if (state_q == SHDR) begin
      tdo    <= dr_out;
      tdo_en <= 1'b1;
    end else begin
      tdo_en <= 1'b0;
    end
  end

  assign capture_en = !(state_q == CAPDR && sel_bsr);
  assign shift_dr   =  (state_q == SHDR  && sel_bsr);
  assign update_en  =  (state_q == UPDDR && sel_bsr);
  assign mode       =  (instr == OP_EXTEST);
  assign tap_state  = state_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed bench for jtag_tap_ctrl. Expected TDO bits go
// into a scoreboard queue as stimulus is driven and are popped on each
// falling edge while shifting. Follows JTAG_TAP_IDCODE_EN like the design.
module tb_jtag_tap_ctrl;

  localparam int          IRW    = 4;
  localparam logic [31:0] ID_VAL = 32'h1234_5677;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0]  RESET_OP = 4'h2;
`else
  localparam logic [3:0]  RESET_OP = 4'hF;
`endif

  logic           tck;
  logic           trst_n;
  logic           tms;
  logic           tdi;
  logic           bsr_so;
  logic           tdo;
  logic           tdo_en;
  logic           capture_en;
  logic           shift_dr;
  logic           update_en;
  logic           mode;
  logic [3:0]     tap_state;
  logic [IRW-1:0] instr;

  int   checks_total  = 0;
  int   checks_passed = 0;
  int   checks_failed = 0;
  logic exp_q[$];
  logic last_tdo;
  logic [31:0] id_bits;
  logic [2:0]  bsr_pat;

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .IDCODE_VAL(ID_VAL)) dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .tms        (tms),
    .tdi        (tdi),
    .bsr_so     (bsr_so),
    .tdo        (tdo),
    .tdo_en     (tdo_en),
    .capture_en (capture_en),
    .shift_dr   (shift_dr),
    .update_en  (update_en),
    .mode       (mode),
    .tap_state  (tap_state),
    .instr      (instr)
  );

  // Free-running test clock, 10 time-unit period.
  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge tck);
    #1;
  endtask

  task automatic checkTdoBit(input string tag);
    logic expected;
    @(negedge tck);
    #1;
    if (exp_q.size() != 0) expected = exp_q.pop_front();
    else                   expected = 1'bx;
    last_tdo = expected;
    checkOutput(tag, 32'(tdo), 32'(expected));
  endtask

  task automatic shiftBits(input int n, input logic [31:0] din,
                           input bit push_tdi, input string tag);
    for (int i = 0; i < n; i++) begin
      checkTdoBit(tag);
      if (i == 0) checkOutput({tag, "_tdo_en"}, 32'(tdo_en), 32'd1);
      if (push_tdi) exp_q.push_back(din[i]);
      applyStimulus(i == n - 1, din[i]);
    end
  endtask

  initial begin
    trst_n = 1'b0;
    tms    = 1'b1;
    tdi    = 1'b0;
    bsr_so = 1'b0;
    id_bits = ID_VAL;

    // Reset defaults while trst_n is held low.
    #12;
    checkOutput("rst_state",   32'(tap_state),  32'hF);
    checkOutput("rst_instr",   32'(instr),      32'(RESET_OP));
    checkOutput("rst_tdo",     32'(tdo),        32'd0);
    checkOutput("rst_tdo_en",  32'(tdo_en),     32'd0);
    checkOutput("rst_capture", 32'(capture_en), 32'd1);
    checkOutput("rst_shift",   32'(shift_dr),   32'd0);
    checkOutput("rst_update",  32'(update_en),  32'd0);
    checkOutput("rst_mode",    32'(mode),       32'd0);
    #10 trst_n = 1'b1;
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("tlr_state",   32'(tap_state),  32'hF);
    checkOutput("tlr_instr",   32'(instr),      32'(RESET_OP));
    checkOutput("tlr_tdo_en",  32'(tdo_en),     32'd0);
    checkOutput("tlr_capture", 32'(capture_en), 32'd1);

    // First DR scan after reset: IDCODE, or BYPASS when IDCODE is absent.
    applyStimulus(0, 0);
    checkOutput("rti_state", 32'(tap_state), 32'hC);
    applyStimulus(1, 0);
    checkOutput("seldr_state", 32'(tap_state), 32'h7);
    applyStimulus(0, 0);
    checkOutput("capdr_state", 32'(tap_state), 32'h6);
    checkOutput("capdr_nobsr_capture", 32'(capture_en), 32'd1);
`ifdef JTAG_TAP_IDCODE_EN
    for (int i = 0; i < 32; i++) exp_q.push_back(id_bits[i]);
    applyStimulus(0, 0);
    checkOutput("shdr_state", 32'(tap_state), 32'h2);
    checkOutput("shdr_nobsr_shift", 32'(shift_dr), 32'd0);
    shiftBits(32, 32'hA5C3_0F96, 1'b0, "idcode");
`else
    exp_q.push_back(1'b0);
    applyStimulus(0, 0);
    checkOutput("shdr_state", 32'(tap_state), 32'h2);
    checkOutput("shdr_nobsr_shift", 32'(shift_dr), 32'd0);
    shiftBits(32, 32'hA5C3_0F96, 1'b1, "first_dr_bypass");
`endif
    exp_q.delete();
    checkOutput("ex1dr_state", 32'(tap_state), 32'h1);
    @(negedge tck);
    #1;
    checkOutput("ex1dr_tdo_en", 32'(tdo_en), 32'd0);
    checkOutput("ex1dr_tdo_hold", 32'(tdo), 32'(last_tdo));
    applyStimulus(1, 0);
    checkOutput("upddr_state", 32'(tap_state), 32'h5);
    checkOutput("upddr_nobsr_update", 32'(update_en), 32'd0);
    applyStimulus(0, 0);

    // IR capture readout and load of EXTEST.
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("selir_state", 32'(tap_state), 32'h4);
    applyStimulus(0, 0);
    checkOutput("capir_state", 32'(tap_state), 32'hE);
    applyStimulus(0, 0);
    checkOutput("shir_state", 32'(tap_state), 32'hA);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    shiftBits(4, 32'h0, 1'b0, "ir_capture");
    checkOutput("ex1ir_state", 32'(tap_state), 32'h9);
    checkOutput("ex1ir_instr_old", 32'(instr), 32'(RESET_OP));
    applyStimulus(1, 0);
    checkOutput("updir_state", 32'(tap_state), 32'hD);
    checkOutput("updir_instr_old", 32'(instr), 32'(RESET_OP));
    applyStimulus(0, 0);
    checkOutput("extest_instr", 32'(instr), 32'h0);
    checkOutput("extest_mode", 32'(mode), 32'd1);

    // EXTEST DR pass: control pulse widths and TDO from bsr_so.
    applyStimulus(1, 0);
    checkOutput("ext_seldr_capture", 32'(capture_en), 32'd1);
    applyStimulus(0, 0);
    checkOutput("ext_capdr_capture", 32'(capture_en), 32'd0);
    checkOutput("ext_capdr_shift", 32'(shift_dr), 32'd0);
    applyStimulus(0, 0);
    checkOutput("ext_shdr_capture", 32'(capture_en), 32'd1);
    checkOutput("ext_shdr_shift0", 32'(shift_dr), 32'd1);
    bsr_pat = 3'b101;
    for (int i = 0; i < 3; i++) begin
      bsr_so = bsr_pat[i];
      exp_q.push_back(bsr_pat[i]);
      checkTdoBit("ext_tdo_bsr");
      if (i < 2) begin
        applyStimulus(0, 0);
        checkOutput("ext_shdr_shift", 32'(shift_dr), 32'd1);
      end else begin
        applyStimulus(1, 0);
      end
    end
    checkOutput("ext_ex1dr_shift", 32'(shift_dr), 32'd0);
    checkOutput("ext_ex1dr_update", 32'(update_en), 32'd0);
    applyStimulus(1, 0);
    checkOutput("ext_upddr_update", 32'(update_en), 32'd1);
    checkOutput("ext_upddr_capture", 32'(capture_en), 32'd1);
    applyStimulus(0, 0);
    checkOutput("ext_rti_update", 32'(update_en), 32'd0);
    bsr_so = 1'b0;

    // Load BYPASS (all ones) and check the one-cycle TDI delay.
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    shiftBits(4, 32'hF, 1'b0, "ir_capture2");
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("bypass_instr", 32'(instr), 32'hF);
    checkOutput("bypass_mode", 32'(mode), 32'd0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    exp_q.push_back(1'b0);
    shiftBits(4, 32'b1101, 1'b1, "bypass");
    applyStimulus(0, 0);
    checkOutput("paudr_state", 32'(tap_state), 32'h3);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    checkOutput("ex2dr_state", 32'(tap_state), 32'h0);
    applyStimulus(0, 0);
    shiftBits(1, 32'h0, 1'b1, "pause_hold");
    exp_q.delete();
    applyStimulus(1, 0);
    applyStimulus(0, 0);

    // Mid-IR-shift escape with five TMS=1 edges (passes through UpdIR).
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      checkTdoBit("midir_tdo");
      applyStimulus(0, 1);
    end
    applyStimulus(1, 1);
    checkOutput("esc_ex1ir_state", 32'(tap_state), 32'h9);
    checkOutput("esc_ex1ir_instr", 32'(instr), 32'hF);
    applyStimulus(1, 1);
    checkOutput("esc_updir_instr", 32'(instr), 32'hF);
    applyStimulus(1, 1);
    checkOutput("esc_seldr_instr", 32'(instr), 32'hE);
    applyStimulus(1, 1);
    applyStimulus(1, 1);
    checkOutput("esc_tlr_state", 32'(tap_state), 32'hF);
    checkOutput("esc_tlr_instr_pending", 32'(instr), 32'hE);
    applyStimulus(1, 1);
    checkOutput("esc_tlr_instr_forced", 32'(instr), 32'(RESET_OP));
    exp_q.delete();

    // Asynchronous trst_n pulse in the middle of a DR shift.
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
`ifdef JTAG_TAP_IDCODE_EN
    exp_q.push_back(id_bits[0]);
`else
    exp_q.push_back(1'b0);
`endif
    checkTdoBit("trst_first_bit");
    applyStimulus(0, 1);
    @(negedge tck);
    #1;
    checkOutput("trst_pre_tdo_en", 32'(tdo_en), 32'd1);
    #2 trst_n = 1'b0;
    #1;
    checkOutput("trst_state", 32'(tap_state), 32'hF);
    checkOutput("trst_tdo_en", 32'(tdo_en), 32'd0);
    checkOutput("trst_tdo", 32'(tdo), 32'd0);
    checkOutput("trst_instr", 32'(instr), 32'(RESET_OP));
    checkOutput("trst_shift", 32'(shift_dr), 32'd0);
    #2 trst_n = 1'b1;
    applyStimulus(1, 0);
    checkOutput("post_trst_state", 32'(tap_state), 32'hF);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
